ov7670_frame_capture: RTL and testbench
=======================================

// Module: ov7670_frame_capture
// PURPOSE
//  Parametrised OV7670 pixel-capture front end; successor to the single-mode RAW8 deserializer.
//  Samples PCLK/HREF/VSYNC/D in the system clock domain and assembles 1- or 2-byte pixels.
//  Optionally decimates 2x/4x and writes pixels to the video buffer write port with linear addresses.
//  Adds single-shot/continuous modes, frame counting and sticky line/frame geometry error flags.
// PARAMETERS
//  H_ACTIVE   640  active pixels per line (camera side, before decimation)
//  V_ACTIVE   480  active lines per frame
//  BPP_BYTES  1    bytes per pixel: 1 = RAW8, 2 = RGB565/YUV (first byte -> MSBs)
//  DECIM      1    decimation factor in x and y: 1, 2 or 4
//  ADDR_W     $clog2((H_ACTIVE/DECIM)*(V_ACTIVE/DECIM))  write address width
// PORTS
//  clk        in   1          system clock, must be >= 4x camera PCLK
//  reset_     in   1          reset: asynchronous, active-high (1 = reset)
//  i_pclk     in   1          camera PCLK (asynchronous, sampled)
//  i_href     in   1          camera HREF, high during active line
//  i_vsync    in   1          camera VSYNC, high pulse in vertical blanking
//  i_d        in   8          camera data byte
//  i_arm      in   1          1-cycle pulse: start capture
//  i_continuous in 1          1 = capture every frame until i_stop; 0 = single frame
//  i_stop     in   1          1-cycle pulse: stop after current frame
//  o_wr_dv    out  1          write strobe, one cycle per kept pixel
//  o_wr_addr  out  ADDR_W     linear pixel address, y*(H_ACTIVE/DECIM)+x (decimated)
//  o_wr_data  out  8*BPP_BYTES assembled pixel
//  o_busy     out  1          state != IDLE
//  o_frame_done out 1         1-cycle pulse when a frame ends (VSYNC rise in CAPTURE)
//  o_frame_cnt out 16         completed frames, wraps 0xFFFF->0
//  o_err_line out  1          sticky: an HREF-high span != H_ACTIVE*BPP_BYTES bytes
//  o_err_frame out 1          sticky: line count at frame end != V_ACTIVE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, sticky errors cleared; only reset or i_arm clears errors.
//  - Inputs pass 2-flop synchronisers; edge detect on synced PCLK/HREF/VSYNC. Byte sampled on synced
//    PCLK rise while synced HREF=1 (D delayed to align with PCLK). Pin-to-o_wr_dv: 3 clk after sync edge
//    of a pixel's last byte (2 sync + 1 output register).
//  - FSM: IDLE -(i_arm)-> WAIT_VS -(VSYNC fall)-> CAPTURE -(VSYNC rise)-> DONE (1 cycle: frame_done,
//    frame_cnt++, check lines) -> WAIT_VS if continuous and no stop pending, else IDLE.
//  - i_arm in non-IDLE ignored; i_stop latched as stop_pending, cleared on entering IDLE.
//  - Byte phase resets to 0 on every HREF rise; pixel completes when phase = BPP_BYTES-1.
//  - x counts completed pixels per line, reset on HREF rise; y increments on HREF fall, reset on VSYNC fall.
//  - Pixel kept iff x%DECIM==0, y%DECIM==0, x<H_ACTIVE, y<V_ACTIVE; out-of-range pixels dropped silently.
//  - Address built incrementally (row base += H_ACTIVE/DECIM per kept row); no multiplier.
//  - HREF fall with byte count != H_ACTIVE*BPP_BYTES -> o_err_line=1; partial pixel discarded.
//  - VSYNC rise mid-line: line ends, counted as short (err_line), then DONE.
//  - DONE with y != V_ACTIVE -> o_err_frame=1; frame still counted.
//  - i_arm and i_stop same cycle in IDLE: arm wins, stop_pending set -> one frame then IDLE.
//  - Reset mid-frame: immediate IDLE, no further o_wr_dv.
// STRUCTURE
//  - Package ov7670_cap_pkg: cap_state_t enum {IDLE,WAIT_VS,CAPTURE,DONE}; localparam helpers
//    for decimated width/height; shared with future capture/VGA blocks.
//  - Sub-module cam_sync_edge: 2-flop synchroniser + rise/fall pulse, instanced for PCLK, HREF, VSYNC.
//  - Top level: FSM, byte assembler, x/y/address counters, error logic, registered outputs.
// TESTING  (bench: H_ACTIVE=8, V_ACTIVE=4, clk = 8x PCLK)
//  - BPP=1, DECIM=1, single-shot, bytes 0x00..0x1F -> 32 writes, addr 0..31, data=byte, one frame_done,
//    frame_cnt=1, busy falls, no errors.
//  - BPP=2, pairs (0xAB,0xCD) -> o_wr_data=0xABCD, 32 writes total for 64 bytes.
//  - DECIM=2 -> 8 writes, addr 0..7, data from x,y in {0,2,4,6}x{0,2}.
//  - Line 2 has 6 bytes -> err_line=1 sticky, remaining lines still written; 3-line frame -> err_frame=1.
//  - Continuous, 3 frames then i_stop mid-frame 3 -> frame_cnt=3, IDLE after 3rd VSYNC rise; i_arm clears errors.
//  - reset_ pulsed mid-line -> outputs 0 next cycle, no writes until re-armed and next VSYNC fall.

Source files
------------

// File: rtl/ov7670_cap_pkg.sv
// Shared types and geometry helpers for the OV7670 capture path.
// Used by the frame-capture front end and intended for later capture/VGA blocks.
//   cap_state_t   : capture FSM state encoding
//   dec_width()   : active width after decimation
//   dec_height()  : active height after decimation
package ov7670_cap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    CAPTURE,
    DONE
  } cap_state_t;

  localparam int unsigned FRAME_CNT_W = 16;

  function automatic int unsigned dec_width(input int unsigned h_active,
                                            input int unsigned decim);
    return h_active / decim;
  endfunction

  function automatic int unsigned dec_height(input int unsigned v_active,
                                             input int unsigned decim);
    return v_active / decim;
  endfunction

endpackage

// File: rtl/ov7670_frame_capture_if.sv
// Video buffer write port driven by the frame-capture block.
//   wr_dv   : write strobe, one cycle per stored pixel
//   wr_addr : linear pixel address
//   wr_data : pixel value
// Modports: master (capture block), slave (buffer).
interface ov7670_frame_capture_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8
);

  logic              wr_dv;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_dv,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_dv,
    input wr_addr,
    input wr_data
  );

endinterface

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser with rise/fall pulse detection for one camera control line.
//   clk     : system clock
//   reset_  : asynchronous active-high reset
//   sig_i   : asynchronous input
//   level_o : synchronised level
//   rise_o  : one-cycle pulse on synchronised 0->1
//   fall_o  : one-cycle pulse on synchronised 1->0
module cam_sync_edge (
  input  logic clk,
  input  logic reset_,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= sig_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/ov7670_frame_capture.sv
// OV7670 pixel-capture front end.
// Samples camera PCLK/HREF/VSYNC/D in the system clock domain, assembles 1- or 2-byte
// pixels, optionally decimates 2x/4x and writes kept pixels to the video buffer.
//   clk, reset_        : system clock (>= 4x PCLK), async active-high reset
//   i_pclk/i_href/i_vsync/i_d : camera pins (asynchronous)
//   i_arm, i_stop      : one-cycle control pulses; i_continuous selects free-running capture
//   wr                 : buffer write port (wr_dv / wr_addr / wr_data)
//   o_busy             : FSM not idle
//   o_frame_done       : one-cycle pulse at frame end
//   o_frame_cnt        : completed frames (wrapping)
//   o_err_line         : sticky, an HREF span had the wrong byte count
//   o_err_frame        : sticky, a frame had the wrong line count
module ov7670_frame_capture
  import ov7670_cap_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned BPP_BYTES = 1,
  parameter int unsigned DECIM     = 1,
  parameter int unsigned ADDR_W    = $clog2((H_ACTIVE / DECIM) * (V_ACTIVE / DECIM))
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   i_pclk,
  input  logic                   i_href,
  input  logic                   i_vsync,
  input  logic [7:0]             i_d,
  input  logic                   i_arm,
  input  logic                   i_continuous,
  input  logic                   i_stop,
  ov7670_frame_capture_if.master wr,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt,
  output logic                   o_err_line,
  output logic                   o_err_frame
);

  localparam int unsigned DataW     = 8 * BPP_BYTES;
  localparam int unsigned LineBytes = H_ACTIVE * BPP_BYTES;
  localparam int unsigned XW        = $clog2(H_ACTIVE + 1) + 1;
  localparam int unsigned YW        = $clog2(V_ACTIVE + 2) + 1;
  localparam int unsigned BW        = $clog2(LineBytes + 2) + 1;

  localparam logic [XW-1:0]     HMax      = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     VMax      = YW'(V_ACTIVE);
  localparam logic [YW-1:0]     YSat      = YW'(V_ACTIVE + 1);
  localparam logic [BW-1:0]     LineBytesW = BW'(LineBytes);
  localparam logic [BW-1:0]     BSat      = BW'(LineBytes + 1);
  localparam logic [ADDR_W-1:0] OutW      = ADDR_W'(dec_width(H_ACTIVE, DECIM));
  localparam logic              PhLast    = 1'(BPP_BYTES - 1);
  // DECIM is a power of two, so x%DECIM == 0 reduces to masking the low bits.
  localparam logic [1:0]        DecMask   = 2'(DECIM - 1);

  // Synchronised camera controls
  logic pclk_lvl, pclk_rise, pclk_fall;
  logic href_lvl, href_rise, href_fall;
  logic vs_lvl, vs_rise, vs_fall;

  cam_sync_edge u_sync_pclk (
    .clk    (clk),
    .reset_ (reset_),
    .sig_i  (i_pclk),
    .level_o(pclk_lvl),
    .rise_o (pclk_rise),
    .fall_o (pclk_fall)
  );

  cam_sync_edge u_sync_href (
    .clk    (clk),
    .reset_ (reset_),
    .sig_i  (i_href),
    .level_o(href_lvl),
    .rise_o (href_rise),
    .fall_o (href_fall)
  );

  cam_sync_edge u_sync_vsync (
    .clk    (clk),
    .reset_ (reset_),
    .sig_i  (i_vsync),
    .level_o(vs_lvl),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  logic unused_sigs;
  assign unused_sigs = ^{pclk_lvl, pclk_fall, vs_lvl};

  cap_state_t state_q, state_d;
  logic       stop_pend_q;

  logic [7:0]             d_meta_q, d_sync_q;
  logic                   phase_q;
  logic [DataW-1:0]       pix_q, pix_asm;
  logic [BW-1:0]          byte_cnt_q;
  logic [XW-1:0]          x_q;
  logic [YW-1:0]          y_q;
  logic                   line_act_q;
  logic [ADDR_W-1:0]      row_base_q, col_q;
  logic                   wr_dv_q;
  logic [ADDR_W-1:0]      wr_addr_q;
  logic [DataW-1:0]       wr_data_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   err_line_q, err_frame_q;

  logic capturing, arm_ok, stop_now, byte_ev, pix_done, keep;
  logic line_end, line_short, row_kept;

  assign capturing = (state_q == CAPTURE);
  assign arm_ok    = (state_q == IDLE) && i_arm;
  assign stop_now  = stop_pend_q | i_stop;

  // HREF rise takes priority; camera HREF moves on PCLK fall so the two never coincide.
  assign byte_ev  = capturing && pclk_rise && href_lvl && !href_rise;
  assign pix_done = byte_ev && (phase_q == PhLast);
  assign keep     = pix_done && (x_q < HMax) && (y_q < VMax) &&
                    ((x_q[1:0] & DecMask) == 2'b00) && ((y_q[1:0] & DecMask) == 2'b00);
  // Truncating the concatenation keeps the first byte in the MSBs for 2-byte pixels.
  assign pix_asm  = DataW'({pix_q, d_sync_q});

  // VSYNC rising during an active line closes it as a short line.
  assign line_end   = capturing && line_act_q && (href_fall || vs_rise);
  assign line_short = vs_rise || (byte_cnt_q != LineBytesW);
  assign row_kept   = (y_q < VMax) && ((y_q[1:0] & DecMask) == 2'b00);

  // FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_arm) state_d = WAIT_VS;
      WAIT_VS: if (vs_fall) state_d = CAPTURE;
      CAPTURE: if (vs_rise) state_d = DONE;
      DONE:    state_d = (i_continuous && !stop_now) ? WAIT_VS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state_q     <= IDLE;
      stop_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != IDLE && state_d == IDLE) begin
        stop_pend_q <= 1'b0;
      end else if (i_stop && (state_q != IDLE || i_arm)) begin
        stop_pend_q <= 1'b1;
      end
    end
  end

  // Datapath: byte assembly, x/y/address counters, errors, registered write port
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      d_meta_q    <= '0;
      d_sync_q    <= '0;
      phase_q     <= 1'b0;
      pix_q       <= '0;
      byte_cnt_q  <= '0;
      x_q         <= '0;
      y_q         <= '0;
      line_act_q  <= 1'b0;
      row_base_q  <= '0;
      col_q       <= '0;
      wr_dv_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_cnt_q <= '0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      // Data bus follows the same two-stage delay as PCLK so it is stable at the sync edge.
      d_meta_q <= i_d;
      d_sync_q <= d_meta_q;

      wr_dv_q <= keep;
      if (keep) begin
        wr_addr_q <= row_base_q + col_q;
        wr_data_q <= pix_asm;
      end

      if (state_q == WAIT_VS && vs_fall) begin
        y_q        <= '0;
        row_base_q <= '0;
        line_act_q <= 1'b0;
      end else if (capturing) begin
        if (href_rise) begin
          line_act_q <= 1'b1;
          phase_q    <= 1'b0;
          byte_cnt_q <= '0;
          x_q        <= '0;
          col_q      <= '0;
        end else if (byte_ev) begin
          pix_q <= pix_asm;
          if (byte_cnt_q != BSat) byte_cnt_q <= byte_cnt_q + 1'b1;
          if (pix_done) begin
            phase_q <= 1'b0;
            if (x_q != HMax) x_q <= x_q + 1'b1;
            if (keep) col_q <= col_q + 1'b1;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        if (line_end) begin
          line_act_q <= 1'b0;
          if (y_q != YSat) y_q <= y_q + 1'b1;
          if (row_kept) row_base_q <= row_base_q + OutW;
          if (line_short) err_line_q <= 1'b1;
        end
      end

      if (state_q == DONE) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
        if (y_q != VMax) err_frame_q <= 1'b1;
      end

      if (arm_ok) begin
        err_line_q  <= 1'b0;
        err_frame_q <= 1'b0;
      end
    end
  end

  assign wr.wr_dv   = wr_dv_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;

  assign o_busy       = (state_q != IDLE);
  assign o_frame_done = (state_q == DONE);
  assign o_frame_cnt  = frame_cnt_q;
  assign o_err_line   = err_line_q;
  assign o_err_frame  = err_frame_q;

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Bench for ov7670_frame_capture: three instances (RAW8, 2-byte pixels, 2x decimation)
// driven by a byte-level camera model; kept pixels are predicted from frame geometry.
module tb_ov7670_frame_capture;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;

  logic clk    = 1'b0;
  logic pclk   = 1'b0;
  logic reset_ = 1'b1;

  logic       href  [3];
  logic       vsync [3];
  logic [7:0] dbyte [3];
  logic       arm   [3];
  logic       cont  [3];
  logic       stop  [3];
  logic        busy   [3];
  logic        fdone  [3];
  logic        eline  [3];
  logic        eframe [3];
  logic [15:0] fcnt   [3];

  always #5 clk = ~clk;
  always #40 pclk = ~pclk;

  ov7670_frame_capture_if #(.ADDR_W(5), .DATA_W(8))  if0 ();
  ov7670_frame_capture_if #(.ADDR_W(5), .DATA_W(16)) if1 ();
  ov7670_frame_capture_if #(.ADDR_W(3), .DATA_W(8))  if2 ();

  ov7670_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP_BYTES(1), .DECIM(1)) u_dut0 (
    .clk(clk), .reset_(reset_), .i_pclk(pclk), .i_href(href[0]), .i_vsync(vsync[0]),
    .i_d(dbyte[0]), .i_arm(arm[0]), .i_continuous(cont[0]), .i_stop(stop[0]), .wr(if0),
    .o_busy(busy[0]), .o_frame_done(fdone[0]), .o_frame_cnt(fcnt[0]),
    .o_err_line(eline[0]), .o_err_frame(eframe[0])
  );

  ov7670_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP_BYTES(2), .DECIM(1)) u_dut1 (
    .clk(clk), .reset_(reset_), .i_pclk(pclk), .i_href(href[1]), .i_vsync(vsync[1]),
    .i_d(dbyte[1]), .i_arm(arm[1]), .i_continuous(cont[1]), .i_stop(stop[1]), .wr(if1),
    .o_busy(busy[1]), .o_frame_done(fdone[1]), .o_frame_cnt(fcnt[1]),
    .o_err_line(eline[1]), .o_err_frame(eframe[1])
  );

  ov7670_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP_BYTES(1), .DECIM(2)) u_dut2 (
    .clk(clk), .reset_(reset_), .i_pclk(pclk), .i_href(href[2]), .i_vsync(vsync[2]),
    .i_d(dbyte[2]), .i_arm(arm[2]), .i_continuous(cont[2]), .i_stop(stop[2]), .wr(if2),
    .o_busy(busy[2]), .o_frame_done(fdone[2]), .o_frame_cnt(fcnt[2]),
    .o_err_line(eline[2]), .o_err_frame(eframe[2])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected writes per instance, encoded as {addr, data[15:0]}
  int unsigned exp_q [3][$];
  int unsigned exp_fc [3];
  int unsigned exp_done [3];
  int unsigned done_cnt [3];
  bit          exp_eline [3];
  bit          exp_eframe [3];

  function automatic int unsigned bpp(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic int unsigned dec(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input int k, input int unsigned addr, input int unsigned data);
    int unsigned e;
    e = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : 32'hDEAD_BEEF;
    check_eq($sformatf("dut%0d_write", k), (addr << 16) | data, e);
  endtask

  always @(negedge clk) begin
    if (if0.wr_dv) check_wr(0, 32'(if0.wr_addr), 32'(if0.wr_data));
    if (if1.wr_dv) check_wr(1, 32'(if1.wr_addr), 32'(if1.wr_data));
    if (if2.wr_dv) check_wr(2, 32'(if2.wr_addr), 32'(if2.wr_data));
    for (int k = 0; k < 3; k++) if (fdone[k]) done_cnt[k]++;
  end

  task automatic pclk_wait(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic do_arm(input int k, input bit c, input bit s);
    @(negedge clk);
    cont[k] = c;
    arm[k]  = 1'b1;
    stop[k] = s;
    @(negedge clk);
    arm[k]  = 1'b0;
    stop[k] = 1'b0;
    exp_eline[k]  = 1'b0;
    exp_eframe[k] = 1'b0;
    @(negedge clk);
    check_eq($sformatf("dut%0d_busy_after_arm", k), 32'(busy[k]), 1);
    check_eq($sformatf("dut%0d_err_line_cleared", k), 32'(eline[k]), 0);
    check_eq($sformatf("dut%0d_err_frame_cleared", k), 32'(eframe[k]), 0);
  endtask

  task automatic do_reset(input int k);
    repeat (2) @(negedge clk);
    check_eq("busy_before_reset", 32'(busy[k]), 1);
    reset_ = 1'b1;
    @(negedge clk);
    check_eq("reset_busy", 32'(busy[k]), 0);
    check_eq("reset_fcnt", 32'(fcnt[k]), 0);
    check_eq("reset_wr_dv", 32'(if0.wr_dv), 0);
    reset_ = 1'b0;
    for (int j = 0; j < 3; j++) begin
      exp_q[j].delete();
      exp_fc[j]     = 0;
      exp_eline[j]  = 1'b0;
      exp_eframe[j] = 1'b0;
    end
  endtask

  // pat: 0 random, 1 incrementing, 2 alternating 0xAB/0xCD.
  // A negative line index disables the stop pulse / bad line / reset.
  task automatic send_frame(input int k, input int nlines, input int bad_line,
                            input int bad_len, input int pat, input int stop_line,
                            input int rst_line, input bit armed);
    int unsigned lb, ctr, pix, ph, x, n, d, w;
    logic [7:0] v;
    bit cap;
    lb  = H * bpp(k);
    d   = dec(k);
    w   = H / d;
    ctr = 0;
    cap = armed;
    vsync[k] = 1'b1;
    pclk_wait(3);
    vsync[k] = 1'b0;
    pclk_wait(3);
    for (int y = 0; y < nlines; y++) begin
      n   = (y == bad_line) ? bad_len : lb;
      pix = 0;
      ph  = 0;
      x   = 0;
      if (y == stop_line) begin
        @(negedge clk) stop[k] = 1'b1;
        @(negedge clk) stop[k] = 1'b0;
      end
      href[k] = 1'b1;
      for (int b = 0; b < int'(n); b++) begin
        if (y == rst_line && b == 3) begin
          do_reset(k);
          cap = 1'b0;
        end
        case (pat)
          0:       v = 8'($urandom);
          1:       v = 8'(ctr);
          default: v = (b % 2 == 0) ? 8'hAB : 8'hCD;
        endcase
        ctr++;
        dbyte[k] = v;
        if (cap) begin
          pix = (pix << 8) | 32'(v);
          ph++;
          if (ph == bpp(k)) begin
            if (x % d == 0 && y % d == 0 && x < H && y < V)
              exp_q[k].push_back(((((y / d) * w) + x / d) << 16) | pix);
            x++;
            ph  = 0;
            pix = 0;
          end
        end
        pclk_wait(1);
      end
      href[k] = 1'b0;
      if (cap && n != lb) exp_eline[k] = 1'b1;
      pclk_wait(2);
    end
    vsync[k] = 1'b1;
    if (cap) begin
      exp_fc[k]++;
      exp_done[k]++;
      if (nlines != V) exp_eframe[k] = 1'b1;
    end
    pclk_wait(3);
  endtask

  task automatic check_frame(input int k, input bit exp_busy);
    int wcnt;
    wcnt = 0;
    while (exp_q[k].size() != 0 && wcnt < 200) begin
      @(negedge clk);
      wcnt++;
    end
    check_eq($sformatf("dut%0d_writes_drained", k), exp_q[k].size(), 0);
    check_eq($sformatf("dut%0d_frame_cnt", k), 32'(fcnt[k]), exp_fc[k]);
    check_eq($sformatf("dut%0d_frame_done_pulses", k), done_cnt[k], exp_done[k]);
    check_eq($sformatf("dut%0d_err_line", k), 32'(eline[k]), 32'(exp_eline[k]));
    check_eq($sformatf("dut%0d_err_frame", k), 32'(eframe[k]), 32'(exp_eframe[k]));
    check_eq($sformatf("dut%0d_busy", k), 32'(busy[k]), 32'(exp_busy));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, bl, blen;
    for (int k = 0; k < 3; k++) begin
      href[k] = 1'b0; vsync[k] = 1'b0; dbyte[k] = 8'h00;
      arm[k] = 1'b0; cont[k] = 1'b0; stop[k] = 1'b0;
      exp_fc[k] = 0; exp_done[k] = 0; done_cnt[k] = 0;
      exp_eline[k] = 1'b0; exp_eframe[k] = 1'b0;
    end
    repeat (4) @(negedge clk);
    reset_ = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("dut%0d_reset_busy", k), 32'(busy[k]), 0);
      check_eq($sformatf("dut%0d_reset_fcnt", k), 32'(fcnt[k]), 0);
      check_eq($sformatf("dut%0d_reset_errs", k), 32'({eline[k], eframe[k], fdone[k]}), 0);
    end

    // RAW8 single shot, bytes 0x00..0x1F
    do_arm(0, 1'b0, 1'b0);
    send_frame(0, 4, -1, 0, 1, -1, -1, 1'b1);
    check_frame(0, 1'b0);

    // 2-byte pixels 0xAB,0xCD
    do_arm(1, 1'b0, 1'b0);
    send_frame(1, 4, -1, 0, 2, -1, -1, 1'b1);
    check_frame(1, 1'b0);

    // 2x decimation
    do_arm(2, 1'b0, 1'b0);
    send_frame(2, 4, -1, 0, 0, -1, -1, 1'b1);
    check_frame(2, 1'b0);

    // Short second line and a 3-line frame
    do_arm(0, 1'b0, 1'b0);
    send_frame(0, 3, 1, 6, 0, -1, -1, 1'b1);
    check_frame(0, 1'b0);

    // Continuous: arm clears errors, stop during third frame
    do_arm(0, 1'b1, 1'b0);
    send_frame(0, 4, -1, 0, 0, -1, -1, 1'b1);
    check_frame(0, 1'b1);
    send_frame(0, 4, -1, 0, 0, -1, -1, 1'b1);
    check_frame(0, 1'b1);
    send_frame(0, 4, -1, 0, 0, 1, -1, 1'b1);
    check_frame(0, 1'b0);

    // Arm and stop together in continuous mode: exactly one frame
    do_arm(0, 1'b1, 1'b1);
    send_frame(0, 4, -1, 0, 0, -1, -1, 1'b1);
    check_frame(0, 1'b0);
    cont[0] = 1'b0;

    // Reset mid-line, then an unarmed frame, then a re-armed frame
    do_arm(0, 1'b0, 1'b0);
    send_frame(0, 4, -1, 0, 0, -1, 1, 1'b1);
    check_frame(0, 1'b0);
    send_frame(0, 4, -1, 0, 0, -1, -1, 1'b0);
    check_frame(0, 1'b0);
    do_arm(0, 1'b0, 1'b0);
    send_frame(0, 4, -1, 0, 0, -1, -1, 1'b1);
    check_frame(0, 1'b0);

    // Random geometry: extra/missing lines, short/long lines
    for (int i = 0; i < 9; i++) begin
      nl   = int'($urandom_range(3, 5));
      bl   = int'($urandom_range(0, 6));
      blen = int'($urandom_range(4, 20));
      do_arm(i % 3, 1'b0, 1'b0);
      send_frame(i % 3, nl, bl, blen, 0, -1, -1, 1'b1);
      check_frame(i % 3, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
